// File: rtl/tx_resp_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// tx_arb_pkg
// Shared types for the TX response arbiter: the FSM state encoding and the
// round-robin grant encoding used by the last_grant flag.
// ----------------------------------------------------------------------------
package tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND_RD     = 2'd1,
        SEND_ALU_LO = 2'd2,
        SEND_ALU_HI = 2'd3
    } tx_state_t;

    // Encoding of the last producer that was granted the FIFO write port.
    localparam logic GNT_ALU = 1'b0;
    localparam logic GNT_RD  = 1'b1;

endpackage

// File: rtl/tx_resp_arbiter_if.sv
// ----------------------------------------------------------------------------
// tx_resp_arbiter_if
// Bundles the producer inputs, FIFO write-side signals, status flags and the
// FSM debug state of tx_resp_arbiter.
//   slave  : the arbiter (consumes producer/FIFO inputs, drives outputs)
//   master : the environment (drives producer/FIFO inputs, observes outputs)
//
// Handshake: i_ALU_VLD / i_RD_VLD are single-cycle pulses with no ready
// signal -- a pulse that finds its slot occupied is dropped and reported on
// o_DROP_ERR. On the FIFO side a byte is transferred on every rising edge
// where o_WR_INC is high; o_WR_INC is never high while i_FIFO_FULL is high,
// and o_FIFO_DATA stays stable until that byte is transferred.
// ----------------------------------------------------------------------------
interface tx_resp_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    import tx_arb_pkg::*;

    logic [2*DATA_WIDTH-1:0] i_ALU_OUT;
    logic                    i_ALU_VLD;
    logic [DATA_WIDTH-1:0]   i_RD_DATA;
    logic                    i_RD_VLD;
    logic                    i_FIFO_FULL;
    logic [DATA_WIDTH-1:0]   o_FIFO_DATA;
    logic                    o_WR_INC;
    logic                    o_ALU_BUSY;
    logic                    o_RD_BUSY;
    logic                    o_DROP_ERR;
    tx_state_t               o_DBG_STATE;

    modport slave (
        input  i_ALU_OUT, i_ALU_VLD, i_RD_DATA, i_RD_VLD, i_FIFO_FULL,
        output o_FIFO_DATA, o_WR_INC, o_ALU_BUSY, o_RD_BUSY, o_DROP_ERR,
               o_DBG_STATE
    );

    modport master (
        output i_ALU_OUT, i_ALU_VLD, i_RD_DATA, i_RD_VLD, i_FIFO_FULL,
        input  o_FIFO_DATA, o_WR_INC, o_ALU_BUSY, o_RD_BUSY, o_DROP_ERR,
               o_DBG_STATE
    );

endinterface

// File: rtl/resp_hold_slot.sv
// ----------------------------------------------------------------------------
// resp_hold_slot
// One-entry holding slot for a response producer.
//   i_CLK   : clock
//   i_RST   : asynchronous active-low reset
//   i_DATA  : producer data, sampled when i_VLD is high
//   i_VLD   : one-cycle valid pulse
//   i_CLR   : the slot's last byte is accepted on this edge
//   o_DATA  : held data
//   o_BUSY  : slot occupied (registered)
//   o_DROP  : combinational; i_VLD arrived while the slot is occupied and
//             not being freed on this edge (the new data is discarded)
// ----------------------------------------------------------------------------
module resp_hold_slot #(
    parameter int WIDTH = 8
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [WIDTH-1:0] i_DATA,
    input  logic             i_VLD,
    input  logic             i_CLR,
    output logic [WIDTH-1:0] o_DATA,
    output logic             o_BUSY,
    output logic             o_DROP
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             w_capture;

    // A slot being freed on this edge may be reloaded on the same edge, so
    // back-to-back responses do not lose a cycle or raise a drop.
    assign w_capture = i_VLD && (!r_valid || i_CLR);

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_data  <= i_DATA;
        end else if (i_CLR) begin
            r_valid <= 1'b0;
        end
    end

    assign o_DATA = r_data;
    assign o_BUSY = r_valid;
    assign o_DROP = i_VLD && r_valid && !i_CLR;

endmodule

// File: rtl/tx_resp_arbiter.sv
// ----------------------------------------------------------------------------
// tx_resp_arbiter
// Shares the TX asynchronous FIFO write port between the ALU result path
// (2-byte word, low byte first) and the register-file read path (1 byte).
// Each producer has a one-entry slot; a round-robin FSM drains the slots
// byte by byte and stalls while the FIFO reports full.
//   i_CLK : REF_CLK-domain clock
//   i_RST : asynchronous active-low reset
//   bus   : tx_resp_arbiter_if.slave
//           inputs  i_ALU_OUT, i_ALU_VLD, i_RD_DATA, i_RD_VLD, i_FIFO_FULL
//           outputs o_FIFO_DATA, o_WR_INC, o_ALU_BUSY, o_RD_BUSY,
//                   o_DROP_ERR, o_DBG_STATE (current FSM state)
// ----------------------------------------------------------------------------
module tx_resp_arbiter
    import tx_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    tx_resp_arbiter_if.slave   bus
);

    tx_state_t               r_state;
    tx_state_t               w_state_nxt;
    logic                    r_last_grant;
    logic                    w_last_grant_nxt;
    logic                    r_drop_err;

    logic [2*DATA_WIDTH-1:0] w_alu_data;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic                    w_alu_busy;
    logic                    w_rd_busy;
    logic                    w_alu_drop;
    logic                    w_rd_drop;
    logic                    w_alu_clr;
    logic                    w_rd_clr;
    logic                    w_wr_inc;
    logic [DATA_WIDTH-1:0]   w_fifo_data;

    // Write strobe depends on the live full flag so a byte goes out on the
    // first cycle the FIFO has room.
    assign w_wr_inc  = (r_state != IDLE) && !bus.i_FIFO_FULL;
    assign w_rd_clr  = (r_state == SEND_RD)     && w_wr_inc;
    assign w_alu_clr = (r_state == SEND_ALU_HI) && w_wr_inc;

    resp_hold_slot #(.WIDTH(2*DATA_WIDTH)) u_alu_slot (
        .i_CLK  (i_CLK),
        .i_RST  (i_RST),
        .i_DATA (bus.i_ALU_OUT),
        .i_VLD  (bus.i_ALU_VLD),
        .i_CLR  (w_alu_clr),
        .o_DATA (w_alu_data),
        .o_BUSY (w_alu_busy),
        .o_DROP (w_alu_drop)
    );

    resp_hold_slot #(.WIDTH(DATA_WIDTH)) u_rd_slot (
        .i_CLK  (i_CLK),
        .i_RST  (i_RST),
        .i_DATA (bus.i_RD_DATA),
        .i_VLD  (bus.i_RD_VLD),
        .i_CLR  (w_rd_clr),
        .o_DATA (w_rd_data),
        .o_BUSY (w_rd_busy),
        .o_DROP (w_rd_drop)
    );

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            r_state      <= IDLE;
            r_last_grant <= GNT_ALU;
            r_drop_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            // Both slots dropping on the same edge still yield one pulse.
            r_drop_err   <= w_alu_drop || w_rd_drop;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            IDLE: begin
                if (w_alu_busy && w_rd_busy) begin
                    // Tie: grant whichever producer did not win last time.
                    if (r_last_grant == GNT_ALU) begin
                        w_state_nxt      = SEND_RD;
                        w_last_grant_nxt = GNT_RD;
                    end else begin
                        w_state_nxt      = SEND_ALU_LO;
                        w_last_grant_nxt = GNT_ALU;
                    end
                end else if (w_rd_busy) begin
                    w_state_nxt      = SEND_RD;
                    w_last_grant_nxt = GNT_RD;
                end else if (w_alu_busy) begin
                    w_state_nxt      = SEND_ALU_LO;
                    w_last_grant_nxt = GNT_ALU;
                end
            end
            SEND_RD: begin
                if (w_wr_inc) w_state_nxt = IDLE;
            end
            // LO goes straight to HI so no RD byte can split an ALU word.
            SEND_ALU_LO: begin
                if (w_wr_inc) w_state_nxt = SEND_ALU_HI;
            end
            SEND_ALU_HI: begin
                if (w_wr_inc) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_fifo_data = '0;
        case (r_state)
            SEND_RD:     w_fifo_data = w_rd_data;
            SEND_ALU_LO: w_fifo_data = w_alu_data[DATA_WIDTH-1:0];
            SEND_ALU_HI: w_fifo_data = w_alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
            default:     w_fifo_data = '0;
        endcase
    end

    assign bus.o_FIFO_DATA = w_fifo_data;
    assign bus.o_WR_INC    = w_wr_inc;
    assign bus.o_ALU_BUSY  = w_alu_busy;
    assign bus.o_RD_BUSY   = w_rd_busy;
    assign bus.o_DROP_ERR  = r_drop_err;
    assign bus.o_DBG_STATE = r_state;

endmodule

// File: doc/tx_resp_arbiter.md
# tx_resp_arbiter

Shares the single write port of the TX-side asynchronous FIFO between two response producers in the REF_CLK domain: the ALU result path (16-bit result, sent as two bytes) and the register-file read path (one byte). Each producer gets a one-entry holding slot; a round-robin FSM drains slots into the FIFO byte by byte, honouring FIFO full back-pressure. It sits between the ALU / register file outputs and the FIFO write interface, replacing direct FIFO writes from the system controller.

## Interface
- DATA_WIDTH, 8, byte width; ALU result is 2*DATA_WIDTH
- i_CLK  in  1  REF_CLK-domain clock
- i_RST  in  1  asynchronous active-low reset
- i_ALU_OUT  in  2*DATA_WIDTH  ALU result
- i_ALU_VLD  in  1  one-cycle pulse, i_ALU_OUT valid
- i_RD_DATA  in  DATA_WIDTH  register-file read data
- i_RD_VLD  in  1  one-cycle pulse, i_RD_DATA valid
- i_FIFO_FULL  in  1  FIFO full flag (write-domain)
- o_FIFO_DATA  out  DATA_WIDTH  byte presented to FIFO
- o_WR_INC  out  1  FIFO write strobe; byte accepted on the rising edge where high
- o_ALU_BUSY  out  1  ALU slot occupied
- o_RD_BUSY  out  1  RD slot occupied
- o_DROP_ERR  out  1  one-cycle pulse: a valid arrived at an occupied slot

## Operation
- Slots: ALU slot (2*DATA_WIDTH + valid), RD slot (DATA_WIDTH + valid). Capture on i_*_VLD when slot empty or being freed on the same edge; otherwise drop data, keep slot unchanged, pulse o_DROP_ERR next cycle (both slots dropping same edge: single pulse).
- o_ALU_BUSY / o_RD_BUSY = registered slot valid bits.
- FSM states: IDLE, SEND_RD, SEND_ALU_LO, SEND_ALU_HI.
  - IDLE: none valid -> stay; one valid -> its SEND state; both -> grant the one not granted last (last_grant flag, reset = ALU, so RD wins first tie). last_grant updated on grant.
  - SEND_RD: byte accepted -> clear RD slot, IDLE.
  - SEND_ALU_LO: accepted -> SEND_ALU_HI. SEND_ALU_HI: accepted -> clear ALU slot, IDLE. ALU word is atomic: no RD byte between LO and HI.
- o_WR_INC = (state is SEND_*) AND NOT i_FIFO_FULL (combinational from registered state and input). Full -> hold state and data, retry every cycle.
- o_FIFO_DATA: SEND_RD -> RD byte; SEND_ALU_LO -> ALU[DATA_WIDTH-1:0]; SEND_ALU_HI -> ALU[2*DATA_WIDTH-1:DATA_WIDTH]; IDLE -> 0.
- Slot data is never modified while its SEND state is active.

## Timing
- Reset (async assert, sync to edge on release): state IDLE, slots empty/zero, last_grant=ALU; o_WR_INC=0, o_FIFO_DATA=0, o_ALU_BUSY=0, o_RD_BUSY=0, o_DROP_ERR=0.
- Latency: valid pulse in cycle N -> slot busy in N+1 -> first o_WR_INC in N+2 (FIFO not full).
- Throughput: one byte per cycle within an ALU word; one IDLE bubble between grants (RD 2 cycles/byte, ALU 3 cycles/word, when not full).
- Free-and-reload: valid on the edge the slot's final byte is accepted -> new data captured, busy stays 1, no drop.
- Reset mid-word (after LO accepted): HI byte lost; FIFO holds orphan LO byte. Accepted behaviour, no recovery.

## Structure
- Package tx_arb_pkg: state enum (IDLE, SEND_RD, SEND_ALU_LO, SEND_ALU_HI), grant encoding constants (GNT_ALU, GNT_RD).
- Sub-module resp_hold_slot (parameter WIDTH): capture/clear/busy/drop logic, instantiated twice (WIDTH=2*DATA_WIDTH, WIDTH=DATA_WIDTH). Top holds FSM, round-robin flag, output mux.

## Test plan
- Single RD: i_RD_DATA=0xA5 pulse, FIFO not full -> o_WR_INC one cycle at N+2 with o_FIFO_DATA=0xA5; o_RD_BUSY 1 for N+1..N+2.
- Single ALU: i_ALU_OUT=0x1234 pulse -> writes 0x34 then 0x12 on consecutive cycles from N+2.
- Simultaneous valid after reset (ALU=0xBEEF, RD=0x5A) -> 0x5A, bubble, 0xEF, 0xBE; repeat with both -> next tie ALU first.
- Back-pressure: i_FIFO_FULL=1 during SEND_ALU_HI for 5 cycles -> o_WR_INC low, o_FIFO_DATA held at HI byte, HI written on first cycle full drops; no RD byte interleaved.
- Drop: second i_RD_VLD (0x77) while RD slot busy and FIFO full -> o_DROP_ERR one-cycle pulse, original byte sent later, 0x77 never written; valid coincident with final accept -> captured, no drop.
- Reset asserted between LO and HI of 0xCAFE -> only 0xFE written, all outputs 0 during reset, clean operation after release.
